vga_timing_gen: RTL

Generates the 640x480@60 Hz VGA raster: horizontal/vertical pixel counters, active-low sync pulses, the active-video flag, and the DrawX/DrawY coordinates consumed by the sprite/ROM/palette renderers.
Also provides sync/blank copies delayed by a parameterised pipeline depth, so the signals stay aligned with RGB produced by renderers that have ROM plus output-register latency.
Sits between the 25 MHz pixel clock and all *_example sprite drawers and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/sync_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived totals and sync window edges.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_timing_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   // First and last column/line of the sync pulses (inclusive)
   localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
   localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

   typedef logic [9:0] coord_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } sync_t;

   // Idle pattern loaded into the delay line on reset: syncs inactive, video blanked
   localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that realigns sync/blank with pipelined RGB.
// Latency: DEPTH clocks (DEPTH=0 is a combinational pass-through).
// Backpressure: none; shifts every clock, reset loads RST_VAL into every stage.
module sync_delay_line #(
   parameter int                 WIDTH   = 3,
   parameter int                 DEPTH   = 2,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         // Clock and reset have no purpose without stages
         logic unused_ctrl;
         assign unused_ctrl = vga_clk ^ reset;
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift one stage per clock; reset flushes all stages to the idle pattern
         always_ff @(posedge vga_clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, active-low syncs, active-video flag, delayed copies.
// Latency: hs/vs/blank valid with DrawX/DrawY; *_d outputs lag by PIPE_DELAY clocks.
// Backpressure: none, free-running. Optional macro VGA_FRAME_COUNT_EN enables frame_count.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = VGA_H_VISIBLE,
   parameter int H_FRONT    = VGA_H_FRONT,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BACK     = VGA_H_BACK,
   parameter int V_VISIBLE  = VGA_V_VISIBLE,
   parameter int V_FRONT    = VGA_V_FRONT,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BACK     = VGA_V_BACK,
   parameter int PIPE_DELAY = 2
) (
   input  logic        vga_clk,
   input  logic        reset,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        hs_d,
   output logic        vs_d,
   output logic        blank_d,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
   localparam coord_t H_ACT      = coord_t'(H_VISIBLE);
   localparam coord_t V_ACT      = coord_t'(V_VISIBLE);
   localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   // Counters are 10 bits wide, so neither total may exceed 1024
   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
         $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
      end
      if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
         $fatal(1, "vga_timing_gen: PIPE_DELAY must be 0..7");
      end
   endgenerate

   coord_t x_nxt;
   coord_t y_nxt;
   logic   hs_nxt;
   logic   vs_nxt;
   logic   blank_nxt;
   logic   at_frame_end;
   sync_t  dly_sync;

   // Next raster position and the sync/blank decode of that position
   always_comb begin
      x_nxt        = DrawX + 10'd1;
      y_nxt        = DrawY;
      at_frame_end = (DrawX == H_LAST) && (DrawY == V_LAST);
      if (DrawX == H_LAST) begin
         x_nxt = '0;
         y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
      end
      hs_nxt    = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
      vs_nxt    = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
      blank_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
   end

   // Register position with its decode so both describe the same pixel
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         DrawX       <= '0;
         DrawY       <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         DrawX       <= x_nxt;
         DrawY       <= y_nxt;
         hs          <= hs_nxt;
         vs          <= vs_nxt;
         blank       <= blank_nxt;
         frame_start <= at_frame_end;
      end
   end

   sync_delay_line #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DELAY),
      .RST_VAL (SYNC_RST)
   ) u_sync_delay (
      .vga_clk (vga_clk),
      .reset   (reset),
      .din     ({hs, vs, blank}),
      .dout    (dly_sync)
   );

   assign hs_d    = dly_sync.hs;
   assign vs_d    = dly_sync.vs;
   assign blank_d = dly_sync.blank;

`ifdef VGA_FRAME_COUNT_EN
   // Count completed frames for sprite animation; wraps naturally at 16 bits
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_count <= '0;
      end else if (frame_start) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`else
   assign frame_count = '0;
`endif

endmodule
